// File: rtl/rfdc_sync_pkg.sv
// Shared types and defaults for the SYSREF phase tracking path.
package rfdc_sync_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    TRACK     = 2'd2
  } state_t;

  localparam int unsigned DEF_PERIOD     = 48;
  localparam int unsigned DEF_STRIDE     = 3;
  localparam int unsigned DEF_LOCK_COUNT = 4;

  // True when the sample stride tiles the sync period exactly.
  function automatic bit period_ok(input int unsigned period, input int unsigned stride);
    return (period >= 2) && (stride != 0) && ((period % stride) == 0);
  endfunction

endpackage

// File: rtl/sysref_edge_find.sv
// Circular rising-edge priority encoder over a sampled SYSREF window.
// Reports the lowest index i with bit i set and bit i-1 (mod NSAMP) clear.
module sysref_edge_find #(
  parameter int unsigned NSAMP = 16,
  parameter int unsigned POS_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NSAMP-1:0] i_phase,
  output logic [POS_W-1:0] o_pos,
  output logic             o_valid
);

  logic             w_found;
  logic [POS_W-1:0] w_pos;
  logic [POS_W-1:0] r_pos;
  logic             r_valid;

  // Lowest-index rising edge, wrapping bit NSAMP-1 onto bit 0.
  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 0; i < NSAMP; i++) begin
      if (!w_found && i_phase[i] && !i_phase[(i == 0) ? NSAMP - 1 : i - 1]) begin
        w_found = 1'b1;
        w_pos   = i[POS_W-1:0];
      end
    end
  end

  // Register the result; position holds when no edge exists.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pos   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_found;
      if (w_found) begin
        r_pos <= w_pos;
      end
    end
  end

  assign o_pos   = r_pos;
  assign o_valid = r_valid;

endmodule

// File: rtl/sysref_phase_tracker.sv
// Samples registered PL_SYSREF at a fixed stride across each sync period,
// tracks window-to-window stability, declares lock, flags off-period syncs
// and reports the rising-edge sample index.
module sysref_phase_tracker
  import rfdc_sync_pkg::*;
#(
  parameter  int unsigned PERIOD     = DEF_PERIOD,
  parameter  int unsigned STRIDE     = DEF_STRIDE,
  parameter  int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter  int unsigned CNT_W      = 8,
  localparam int unsigned NSAMP      = PERIOD / STRIDE,
  localparam int unsigned POS_W      = (NSAMP > 1) ? $clog2(NSAMP) : 1
) (
  input  logic             sysclk_i,
  input  logic             rst_n_i,
  input  logic             sync_i,
  input  logic             sysref_i,
  input  logic             arm_i,
  output logic [NSAMP-1:0] phase_o,
  output logic             phase_valid_o,
  output logic [POS_W-1:0] edge_pos_o,
  output logic             edge_valid_o,
  output logic [CNT_W-1:0] stable_cnt_o,
  output logic             locked_o,
  output logic             sync_err_o
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam logic [CNT_W:0] LOCK_TH = (CNT_W + 1)'(LOCK_COUNT - 1);

  if (!period_ok(PERIOD, STRIDE)) begin : g_bad_period
    $error("sysref_phase_tracker: PERIOD must be >= 2 and a multiple of STRIDE");
  end

  state_t           r_state;
  logic [PW-1:0]    r_ph;
  logic [NSAMP-1:0] r_cap;
  logic [NSAMP-1:0] r_phase;
  logic             r_phase_valid;
  logic [CNT_W-1:0] r_stable_cnt;
  logic             r_locked;
  logic             r_sync_err;
  logic             r_first;

  logic [PW-1:0]    w_ph_eff;
  logic             w_win_end;
  logic             w_off_sync;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_ph_eff   = sync_i ? '0 : r_ph;
  assign w_win_end  = (w_ph_eff == PW'(PERIOD - 1));
  assign w_off_sync = sync_i && (r_ph != '0);
  assign w_match    = !r_first && (r_cap == r_phase);
  assign w_cnt_inc  = (r_stable_cnt == '1) ? r_stable_cnt : r_stable_cnt + 1'b1;
  assign w_cnt_next = w_match ? w_cnt_inc : '0;

  // Free-running phase counter, realigned by sync; capture samples on stride points.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      r_ph  <= '0;
      r_cap <= '0;
    end else begin
      r_ph <= w_win_end ? '0 : w_ph_eff + 1'b1;
      for (int unsigned i = 0; i < NSAMP; i++) begin
        if (w_ph_eff == PW'(STRIDE * i)) begin
          r_cap[i] <= sysref_i;
        end
      end
    end
  end

  // Tracking FSM with registered phase word, stability counter, lock and sync error.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_stable_cnt  <= '0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_first       <= 1'b1;
    end else begin
      r_phase_valid <= 1'b0;
      if (!arm_i) begin
        // Disarm beats a coincident window end: no phase update is issued.
        r_state      <= IDLE;
        r_stable_cnt <= '0;
        r_locked     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= WAIT_SYNC;
            r_sync_err <= 1'b0;
          end
          WAIT_SYNC: begin
            if (sync_i) begin
              r_state <= TRACK;
              r_first <= 1'b1;
            end
          end
          TRACK: begin
            if (w_off_sync) begin
              // Partial window is dropped; the restarted one is not compared.
              r_sync_err   <= 1'b1;
              r_stable_cnt <= '0;
              r_locked     <= 1'b0;
              r_first      <= 1'b1;
            end else if (w_win_end) begin
              r_phase       <= r_cap;
              r_phase_valid <= 1'b1;
              r_stable_cnt  <= w_cnt_next;
              r_locked      <= ({1'b0, w_cnt_next} >= LOCK_TH);
              r_first       <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  sysref_edge_find #(
    .NSAMP (NSAMP),
    .POS_W (POS_W)
  ) u_edge_find (
    .i_clk   (sysclk_i),
    .i_rst_n (rst_n_i),
    .i_phase (r_phase),
    .o_pos   (edge_pos_o),
    .o_valid (edge_valid_o)
  );

  assign phase_o       = r_phase;
  assign phase_valid_o = r_phase_valid;
  assign stable_cnt_o  = r_stable_cnt;
  assign locked_o      = r_locked;
  assign sync_err_o    = r_sync_err;

endmodule

// File: tb/tb_sysref_phase_tracker.sv
// Self-checking bench for sysref_phase_tracker at default parameters.
module tb_sysref_phase_tracker;

  localparam int unsigned P = 48;

  logic        clk;
  logic        rst_n;
  logic        sync;
  logic        sysref;
  logic        arm;
  logic [15:0] phase;
  logic        phase_valid;
  logic [3:0]  edge_pos;
  logic        edge_valid;
  logic [7:0]  stable_cnt;
  logic        locked;
  logic        sync_err;

  sysref_phase_tracker #(
    .PERIOD     (48),
    .STRIDE     (3),
    .LOCK_COUNT (4),
    .CNT_W      (8)
  ) dut (
    .sysclk_i      (clk),
    .rst_n_i       (rst_n),
    .sync_i        (sync),
    .sysref_i      (sysref),
    .arm_i         (arm),
    .phase_o       (phase),
    .phase_valid_o (phase_valid),
    .edge_pos_o    (edge_pos),
    .edge_valid_o  (edge_valid),
    .stable_cnt_o  (stable_cnt),
    .locked_o      (locked),
    .sync_err_o    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned lo;
    int unsigned hi;
    int unsigned nwin;
    logic [15:0] phase;
    logic [3:0]  pos;
    logic        ev;
  } vec_t;

  typedef struct {
    logic [15:0] phase;
    logic [3:0]  pos;
    logic        ev;
    int unsigned cnt;
    logic        locked;
  } exp_t;

  typedef enum int {M_IDLE, M_WAIT, M_TRACK} mstate_t;

  vec_t        tbl [6];
  vec_t        cur;
  exp_t        q [$];
  exp_t        pend;
  bit          have_pend;
  int unsigned tb_ph;
  mstate_t     m_state;
  bit          m_err;
  bit          m_first;
  int unsigned m_cnt;
  logic [15:0] m_phase;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = M_IDLE;
    m_err     = 1'b0;
    m_first   = 1'b1;
    m_cnt     = 0;
    m_phase   = '0;
    have_pend = 1'b0;
    q.delete();
    tb_ph     = 0;
  endtask

  // Compare outputs produced by the edge that just passed.
  task automatic check_outputs();
    exp_t it;
    if (have_pend) begin
      chk("edge_pos", 32'(edge_pos), 32'(pend.pos));
      chk("edge_valid", 32'(edge_valid), 32'(pend.ev));
      have_pend = 1'b0;
    end
    if (phase_valid || q.size() != 0) begin
      chk("phase_valid", 32'(phase_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        it = q.pop_front();
        if (phase_valid) begin
          chk("phase", 32'(phase), 32'(it.phase));
          chk("stable_cnt", 32'(stable_cnt), it.cnt);
          chk("locked", 32'(locked), 32'(it.locked));
          pend      = it;
          have_pend = 1'b1;
        end
      end
    end
    chk("sync_err", 32'(sync_err), 32'(m_err));
  endtask

  // One SYSCLK cycle: drive inputs, advance the reference model, check after the edge.
  task automatic drive_cycle(input bit force_sync);
    bit          s;
    int unsigned eff;
    exp_t        e;
    s      = force_sync || (tb_ph == 0);
    eff    = s ? 0 : tb_ph;
    sync   = s;
    sysref = (eff >= cur.lo) && (eff <= cur.hi);
    if (!arm) begin
      m_state = M_IDLE;
      m_cnt   = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          m_state = M_WAIT;
          m_err   = 1'b0;
        end
        M_WAIT: begin
          if (s) begin
            m_state = M_TRACK;
            m_first = 1'b1;
          end
        end
        default: begin
          if (s && tb_ph != 0) begin
            m_err   = 1'b1;
            m_cnt   = 0;
            m_first = 1'b1;
          end else if (eff == P - 1) begin
            if (!m_first && cur.phase == m_phase) m_cnt++;
            else m_cnt = 0;
            m_phase  = cur.phase;
            m_first  = 1'b0;
            e.phase  = cur.phase;
            e.pos    = cur.pos;
            e.ev     = cur.ev;
            e.cnt    = m_cnt;
            e.locked = (m_cnt >= 3);
            q.push_back(e);
          end
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    tb_ph = (eff == P - 1) ? 0 : eff + 1;
    check_outputs();
  endtask

  // Run until the DUT is waiting for sync and the next cycle carries one.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!(tb_ph == 0 && m_state == M_WAIT) && n < 4 * P) begin
      drive_cycle(1'b0);
      n++;
    end
    chk("wait_ready", 32'(tb_ph == 0 && m_state == M_WAIT), 32'd1);
  endtask

  task automatic run_entry(input int k);
    cur = tbl[k];
    for (int unsigned w = 0; w < tbl[k].nwin; w++) begin
      for (int unsigned c = 0; c < P; c++) drive_cycle(1'b0);
    end
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    sync  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_phase_valid", 32'(phase_valid), 32'h0);
    chk("rst_edge_pos", 32'(edge_pos), 32'h0);
    chk("rst_edge_valid", 32'(edge_valid), 32'h0);
    chk("rst_stable_cnt", 32'(stable_cnt), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_sync_err", 32'(sync_err), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{lo: 24, hi: 47, nwin: 5, phase: 16'hFF00, pos: 4'd8, ev: 1'b1};
    tbl[1] = '{lo: 21, hi: 47, nwin: 4, phase: 16'hFF80, pos: 4'd7, ev: 1'b1};
    tbl[2] = '{lo: 0,  hi: 23, nwin: 4, phase: 16'h00FF, pos: 4'd0, ev: 1'b1};
    tbl[3] = '{lo: 0,  hi: 47, nwin: 2, phase: 16'hFFFF, pos: 4'd0, ev: 1'b0};
    tbl[4] = '{lo: 10, hi: 30, nwin: 2, phase: 16'h07F0, pos: 4'd4, ev: 1'b1};
    tbl[5] = '{lo: 48, hi: 0,  nwin: 2, phase: 16'h0000, pos: 4'd4, ev: 1'b0};
    n_cmp  = 0;
    n_bad  = 0;
    cur    = tbl[0];
    rst_n  = 1'b0;
    sync   = 1'b0;
    sysref = 1'b0;
    arm    = 1'b0;
    @(negedge clk);
    reset_cycle();

    // Steady lock, then phase step and relock.
    arm = 1'b1;
    wait_ready();
    run_entry(0);
    run_entry(1);
    chk("relocked", 32'(locked), 32'd1);

    // Off-period sync 47 cycles after the previous one while locked.
    for (int c = 0; c < 47; c++) drive_cycle(1'b0);
    drive_cycle(1'b1);
    chk("offsync_err", 32'(sync_err), 32'd1);
    chk("offsync_locked", 32'(locked), 32'd0);
    chk("offsync_cnt", 32'(stable_cnt), 32'd0);
    while (tb_ph != 0) drive_cycle(1'b0);
    arm = 1'b0;
    drive_cycle(1'b0);
    chk("err_held_disarmed", 32'(sync_err), 32'd1);
    arm = 1'b1;
    drive_cycle(1'b0);
    chk("err_cleared_rearm", 32'(sync_err), 32'd0);

    // Wrap edge pattern, then disarm on a window-end cycle.
    wait_ready();
    run_entry(2);
    chk("wrap_locked", 32'(locked), 32'd1);
    for (int c = 0; c < 47; c++) drive_cycle(1'b0);
    arm = 1'b0;
    drive_cycle(1'b0);
    chk("disarm_locked", 32'(locked), 32'd0);
    chk("disarm_cnt", 32'(stable_cnt), 32'd0);
    chk("disarm_phase_hold", 32'(phase), 32'h00FF);
    chk("disarm_pos_hold", 32'(edge_pos), 32'd0);
    arm = 1'b1;

    // All-high, mid-window pulse, all-low.
    wait_ready();
    run_entry(3);
    run_entry(4);
    run_entry(5);

    // Reset mid-window, then a fresh tracking run.
    cur = tbl[4];
    for (int c = 0; c < 21; c++) drive_cycle(1'b0);
    reset_cycle();
    wait_ready();
    run_entry(4);
    drive_cycle(1'b0);
    drive_cycle(1'b0);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sysref_phase_tracker.md
# sysref_phase_tracker

Parametrised successor to the PL_SYSREF phase capture. It runs in the SYSCLK domain and samples an already-registered PL_SYSREF at a programmable stride across each SYSCLK sync period. It then:
- tracks the captured pattern window-to-window,
- declares lock after N identical windows,
- flags irregular sync pulses,
- reports the SYSREF rising-edge position as a sample index.

It sits between the SYSREF input flop and the register/monitoring path that today reads a raw 16-bit phase word.

## Interface
Parameters:
- PERIOD, 48: SYSCLK cycles between sync pulses; ≥ 2.
- STRIDE, 3: cycles between samples; PERIOD % STRIDE == 0.
- NSAMP, PERIOD/STRIDE: samples per window (derived; default 16).
- LOCK_COUNT, 4: consecutive identical windows required for lock; ≥ 1.
- CNT_W, 8: width of the stable-window counter (saturating).

Ports (one clock; reset is synchronous and active-low):
- sysclk_i  in  1  SYSCLK; all logic on its rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- sync_i  in  1  sync pulse; one cycle high per PERIOD.
- sysref_i  in  1  PL_SYSREF already registered in sysclk_i.
- arm_i  in  1  level; high = track, low = idle.
- phase_o  out  NSAMP  last completed window; bit i = sample i.
- phase_valid_o  out  1  one-cycle strobe when phase_o updates.
- edge_pos_o  out  $clog2(NSAMP)  rising-edge sample index.
- edge_valid_o  out  1  high when phase_o contains exactly-defined rising edge(s).
- stable_cnt_o  out  CNT_W  consecutive identical windows minus 1.
- locked_o  out  1  high while stable_cnt_o ≥ LOCK_COUNT-1.
- sync_err_o  out  1  sticky; a sync arrived off-period while tracking.

## Operation
- Phase counter ph, range 0..PERIOD-1:
  - ph_eff = sync_i ? 0 : ph.
  - ph <= (ph_eff == PERIOD-1) ? 0 : ph_eff+1.
  - The counter free-runs, so a missing sync wraps silently.
- Sample i is captured into cap[i] on the cycle ph_eff == STRIDE*i. The sync cycle itself is sample 0.
- FSM states:
  - IDLE: if arm_i, go to WAIT_SYNC.
  - WAIT_SYNC: on sync_i, go to TRACK. Sample 0 is taken this cycle. The first sync is never an error.
  - TRACK: window end is ph_eff == PERIOD-1. On window end:
    - phase_o <= cap; phase_valid_o pulses.
    - If cap == phase_o and this is not the first window since arm, stable_cnt increments (saturating at 2^CNT_W-1); otherwise stable_cnt <= 0.
  - Any state: arm_i low returns the FSM to IDLE. It also clears stable_cnt and locked_o. phase_o and edge_* hold.
- Off-period sync, i.e. sync_i in TRACK with ph != 0:
  - Set sync_err_o and clear stable_cnt.
  - Discard the partial window (no phase_valid_o).
  - Restart capture with this cycle as sample 0.
  - The next window end still counts as the first window, so no comparison is made against the old phase_o.
- sync_err_o clears only on reset or on the IDLE→WAIT_SYNC transition.
- Edge find on phase_o: the result is the lowest i with phase_o[i]=1 and phase_o[(i-1) mod NSAMP]=0, with wrap at i=0. If phase_o is all-0 or all-1, edge_valid_o=0 and edge_pos_o holds.
- Reset values:
  - phase_o=0, edge_pos_o=0, stable_cnt_o=0.
  - phase_valid_o, edge_valid_o, locked_o, sync_err_o = 0.
  - State IDLE, ph=0, cap=0.

## Timing
- phase_o and phase_valid_o are registered from the window-end cycle, so they are visible 1 cycle after it.
- edge_pos_o and edge_valid_o are registered from phase_o: 2 cycles after window end.
- stable_cnt_o and locked_o update with phase_o (1 cycle).
- sync_err_o is set the cycle after the offending sync.
- Sync coincident with window end (the normal case): the window end uses the old cap; sample 0 of the new window is written the same cycle. No hazard.
- arm_i falling on a window-end cycle: IDLE wins and no phase_valid_o is issued.
- Reset mid-window: all state returns to reset values on the next edge. Partial data is discarded.

## Structure
- Shared package rfdc_sync_pkg holds:
  - the state enum (IDLE, WAIT_SYNC, TRACK),
  - default PERIOD, STRIDE, LOCK_COUNT,
  - a function checking PERIOD % STRIDE.
- An elaboration-time assertion fails on non-integer NSAMP.
- One sub-module, sysref_edge_find: parametrised NSAMP circular rising-edge priority encoder with a registered output.

## Test plan
- Steady lock. sysref high for ph 24..47 every period, arm=1 → phase_o=16'hFF00, edge_pos_o=8, edge_valid_o=1. locked_o rises at the 4th window end +1.
- Phase step. After lock, move the high interval to ph 21..47 → phase_o=16'hFF80, edge_pos_o=7, locked_o drops, stable_cnt_o=0. Relock after 3 further identical windows.
- Wrap edge. Set sysref high ph 0..23 → phase_o=16'h00FF, edge_pos_o=0. All-high input → 16'hFFFF, edge_valid_o=0, edge_pos_o held.
- Off-period sync. Issue a sync 47 cycles after the previous one while locked → sync_err_o=1, locked_o=0, no phase_valid_o for the truncated window. Re-arm (arm 0→1) → sync_err_o=0.
- Reset and disarm:
  - rst_n_i low for 1 cycle mid-window → all outputs zero, state IDLE.
  - arm_i low on a window-end cycle → no phase_valid_o, locked_o=0, phase_o unchanged.
